// File: rtl/map_gen.sv
// Minefield map generator: places MINE_NUM mines with an LFSR (never on the safe cell),
// then writes one packed cell per cycle: 9 for a mine, otherwise its adjacent-mine count.
module map_gen #(
  parameter int unsigned MAP_WIDTH  = 8,
  parameter int unsigned MAP_HEIGHT = 8,
  parameter int unsigned CELL_LEN   = 4,
  parameter int unsigned MINE_NUM   = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic [5:0]                               first_pos_i,
  output logic [CELL_LEN*MAP_WIDTH*MAP_HEIGHT-1:0] map_o,
  output logic                                     busy_o,
  output logic                                     done_o
);

  localparam int unsigned Cells   = MAP_WIDTH * MAP_HEIGHT;
  localparam logic [2:0]  XMax    = 3'(MAP_WIDTH - 1);
  localparam logic [2:0]  YMax    = 3'(MAP_HEIGHT - 1);
  localparam logic [5:0]  MineCnt = 6'(MINE_NUM);
  localparam logic [5:0]  LastK   = 6'(Cells - 1);

  typedef enum logic [1:0] {StIdle, StPlace, StCount, StDone} state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic [15:0]                 r_lfsr;
  logic [15:0]                 w_lfsr_next;
  logic [Cells-1:0]            r_bitmap;
  logic [5:0]                  r_cnt;
  logic [5:0]                  r_first;
  logic [5:0]                  r_k;
  logic [CELL_LEN*Cells-1:0]   r_map;

  logic [5:0]                  w_cand;
  logic                        w_accept;
  logic [2:0]                  w_kx;
  logic [2:0]                  w_ky;
  logic                        w_xl;
  logic                        w_xr;
  logic                        w_yu;
  logic                        w_yd;
  logic [7:0]                  w_nb;
  logic [3:0]                  w_nsum;
  logic [CELL_LEN-1:0]         w_cell;

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  assign w_cand   = r_lfsr[5:0];
  assign w_accept = !r_bitmap[w_cand] && (w_cand != r_first) && (r_cnt != MineCnt);

  assign w_kx = r_k[2:0];
  assign w_ky = r_k[5:3];
  assign w_xl = (w_kx != 3'd0);
  assign w_xr = (w_kx != XMax);
  assign w_yu = (w_ky != 3'd0);
  assign w_yd = (w_ky != YMax);

  // Edge gating makes the 6-bit index wraparound harmless and blocks row wrap.
  assign w_nb[0] = w_xl         & r_bitmap[r_k - 6'd1];
  assign w_nb[1] = w_xr         & r_bitmap[r_k + 6'd1];
  assign w_nb[2] = w_yu         & r_bitmap[r_k - 6'd8];
  assign w_nb[3] = w_yd         & r_bitmap[r_k + 6'd8];
  assign w_nb[4] = w_xl & w_yu  & r_bitmap[r_k - 6'd9];
  assign w_nb[5] = w_xr & w_yu  & r_bitmap[r_k - 6'd7];
  assign w_nb[6] = w_xl & w_yd  & r_bitmap[r_k + 6'd7];
  assign w_nb[7] = w_xr & w_yd  & r_bitmap[r_k + 6'd9];

  always_comb begin
    w_nsum = '0;
    for (int i = 0; i < 8; i++) begin
      w_nsum = w_nsum + 4'(w_nb[i]);
    end
  end

  assign w_cell = r_bitmap[r_k] ? CELL_LEN'(4'd9) : CELL_LEN'(w_nsum);

  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) w_state_next = StPlace;
      end
      StPlace: begin
        busy_o = 1'b1;
        if (r_cnt == MineCnt) w_state_next = StCount;
      end
      StCount: begin
        busy_o = 1'b1;
        if (r_k == LastK) w_state_next = StDone;
      end
      StDone: begin
        done_o       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_lfsr   <= LFSR_SEED;
      r_bitmap <= '0;
      r_cnt    <= '0;
      r_first  <= '0;
      r_k      <= '0;
      r_map    <= '0;
    end else begin
      r_state <= w_state_next;
      r_lfsr  <= w_lfsr_next;
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_first  <= first_pos_i;
            r_bitmap <= '0;
            r_cnt    <= '0;
            r_k      <= '0;
          end
        end
        StPlace: begin
          if (w_accept) begin
            r_bitmap[w_cand] <= 1'b1;
            r_cnt            <= r_cnt + 6'd1;
          end
        end
        StCount: begin
          r_map[int'(r_k)*CELL_LEN +: CELL_LEN] <= w_cell;
          r_k                                   <= r_k + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign map_o = r_map;

endmodule

// File: tb/tb_map_gen.sv
// Randomised bench for map_gen: each generation is compared against a software minefield
// built from the LFSR state captured at the accepted start.
module tb_map_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_a, start_b;
  logic [5:0]   fp_a, fp_b;
  logic [255:0] map_a, map_b;
  logic         busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  bit           cur_sel;
  logic [255:0] c_map;
  logic         c_busy, c_done;

  logic [15:0]  m_lfsr;

  always #5 clk = ~clk;

  map_gen #(.MINE_NUM(10)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_a),
    .first_pos_i(fp_a),
    .map_o      (map_a),
    .busy_o     (busy_a),
    .done_o     (done_a)
  );

  map_gen #(.MINE_NUM(63)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_b),
    .first_pos_i(fp_b),
    .map_o      (map_b),
    .busy_o     (busy_b),
    .done_o     (done_b)
  );

  assign c_map  = cur_sel ? map_b  : map_a;
  assign c_busy = cur_sel ? busy_b : busy_a;
  assign c_done = cur_sel ? done_b : done_a;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int b;
    b = ((int'(v) >> 0) ^ (int'(v) >> 2) ^ (int'(v) >> 3) ^ (int'(v) >> 5)) & 1;
    return 16'((int'(v) >> 1) | (b << 15));
  endfunction

  // Reference LFSR runs free from reset, exactly like the generator's.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic void build_map(input logic [15:0] s, input int first, input int nmines,
                                    output logic [255:0] m, output int steps);
    bit          mine[64];
    int          placed;
    int          c;
    int          n;
    logic [15:0] v;
    for (int i = 0; i < 64; i++) mine[i] = 0;
    placed = 0;
    steps  = 0;
    v      = s;
    while (placed < nmines && steps < 100000) begin
      v = lfsr_step(v);
      steps++;
      c = int'(v) % 64;
      if (!mine[c] && c != first) begin
        mine[c] = 1;
        placed++;
      end
    end
    m = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (mine[y*8+x]) begin
          m[(y*8+x)*4 +: 4] = 4'd9;
        end else begin
          n = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < 8 && y+dy >= 0 && y+dy < 8)
                n += int'(mine[(y+dy)*8 + x+dx]);
          m[(y*8+x)*4 +: 4] = 4'(n);
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered and left on a negedge. abort_mode: 0 none, 1 reset in PLACE, 2 reset at COUNT k=30.
  task automatic run_gen(input bit sel, input logic [5:0] fp, input string tag,
                         input int poke_at, input int abort_mode);
    logic [255:0] exp;
    int           steps, busy_cnt, nmines, mines_seen;
    bit           got_done;
    cur_sel  = sel;
    nmines   = sel ? 63 : 10;
    build_map(m_lfsr, int'(fp), nmines, exp, steps);
    if (sel) begin start_b = 1'b1; fp_b = fp; end
    else     begin start_a = 1'b1; fp_a = fp; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_busy_rise"}, 256'(c_busy), 256'(1));
    busy_cnt = 0;
    got_done = 0;
    for (int i = 0; i < 20000; i++) begin
      if ((abort_mode == 1 && i == 2) || (abort_mode == 2 && i == steps + 31)) begin
        rst = 1'b1;
        #1;
        check({tag, "_abort_map"},  c_map,          256'(0));
        check({tag, "_abort_busy"}, 256'(c_busy),   256'(0));
        check({tag, "_abort_done"}, 256'(c_done),   256'(0));
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (sel) start_b = (i == poke_at);
      else     start_a = (i == poke_at);
      if (c_done) begin
        got_done = 1;
        break;
      end
      if (c_busy) busy_cnt++;
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_done_seen"},  256'(got_done), 256'(1));
    check({tag, "_busy_at_done"}, 256'(c_busy), 256'(0));
    check({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(steps + 65));
    check({tag, "_map"}, c_map, exp);
    mines_seen = 0;
    for (int i = 0; i < 64; i++) if (c_map[i*4 +: 4] == 4'd9) mines_seen++;
    check({tag, "_mine_count"}, 256'(mines_seen), 256'(nmines));
    check({tag, "_safe_cell"}, 256'(c_map[int'(fp)*4 +: 4] == 4'd9), 256'(0));
    @(negedge clk);
    check({tag, "_done_single"}, 256'(c_done), 256'(0));
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    fp_a    = '0;
    fp_b    = '0;
    cur_sel = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rst     = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_map_a",  map_a,          256'(0));
    check("idle_busy_a", 256'(busy_a),   256'(0));
    check("idle_done_a", 256'(done_a),   256'(0));
    check("idle_map_b",  map_b,          256'(0));
    check("idle_busy_b", 256'(busy_b),   256'(0));

    run_gen(0, 6'd0,  "first0", -1, 0);
    // Corner 0 and no-wrap case; full-map compare above covers every cell.
    repeat (3) @(negedge clk);
    run_gen(0, 6'(30 + $urandom_range(0, 5)), "poke", 5, 0);
    run_gen(0, 6'($urandom_range(0, 63)), "back2back", -1, 0);

    run_gen(0, 6'd9,  "abort_place", -1, 1);
    run_gen(0, 6'd9,  "after_abort1", -1, 0);
    run_gen(0, 6'd40, "abort_count", -1, 2);
    run_gen(0, 6'd40, "after_abort2", -1, 0);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_gen(0, 6'($urandom_range(0, 63)), $sformatf("rand%0d", r), -1, 0);
    end

    run_gen(1, 6'd27, "full27", -1, 0);
    check("full27_cell", 256'(map_b[27*4 +: 4]), 256'(8));
    run_gen(1, 6'd0, "full0", -1, 0);
    check("full0_cell", 256'(map_b[0 +: 4]), 256'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
